pd1_pwr_handshake: RTL

PD1-side responder to the power controller's sleep/wake protocol. It receives `sleep_req` and the DC-DC rail enable, sequences PD1 isolation, clock gating and reset, and returns `hw_sleep_ack` and `pwr_on_ack` to the power controller. Placement is the always-on domain, at the PD0/PD1 boundary, driving PD1's isolation cells and reset. The block is the acknowledge end of the handshake whose request end is the DC-DC enable/delay logic in `power_controller`.

---
 rtl/pd1_pwr_handshake_if.sv | 31 +++
 rtl/pd1_pwr_handshake.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pd1_pwr_handshake_if.sv
// Handshake bundle between the power controller and the PD1 sleep/wake responder.
// The power controller side uses master; the responder uses slave.
interface pd1_pwr_handshake_if;
  logic       i_sleep_req;
  logic       i_dcdc_enable;
  logic       i_pd1_idle;
  logic [7:0] i_settle_cycles;
  logic [7:0] i_idle_timeout;
  logic       i_err_clr;
  logic       o_hw_sleep_ack;
  logic       o_pwr_on_ack;
  logic       o_iso_en;
  logic       o_pd1_clk_en;
  logic       o_pd1_rst_n;
  logic       o_timeout_err;
  logic [2:0] o_state;

  modport master (
    output i_sleep_req, i_dcdc_enable, i_pd1_idle, i_settle_cycles,
           i_idle_timeout, i_err_clr,
    input  o_hw_sleep_ack, o_pwr_on_ack, o_iso_en, o_pd1_clk_en,
           o_pd1_rst_n, o_timeout_err, o_state
  );

  modport slave (
    input  i_sleep_req, i_dcdc_enable, i_pd1_idle, i_settle_cycles,
           i_idle_timeout, i_err_clr,
    output o_hw_sleep_ack, o_pwr_on_ack, o_iso_en, o_pd1_clk_en,
           o_pd1_rst_n, o_timeout_err, o_state
  );
endinterface

// File: rtl/pd1_pwr_handshake.sv
// PD1 acknowledge end of the sleep/wake handshake: sequences isolation, clock gate
// and reset of PD1 and returns hw_sleep_ack / pwr_on_ack to the power controller.
module pd1_pwr_handshake (
  input logic                i_aon_clk,
  input logic                i_soc_pwr_on_rst_n,
  pd1_pwr_handshake_if.slave bus
);

  typedef enum logic [2:0] {
    RAIL_WAIT = 3'd0,
    RELEASE   = 3'd1,
    ON        = 3'd2,
    DRAIN     = 3'd3,
    CLAMP     = 3'd4,
    SLEEP     = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] settle_last;
  logic [7:0] timeout_last;
  logic       idle_meta, idle_s;
  logic       err_set;
  logic       timeout_err_q;
  logic       iso_q, clk_en_q, rst_n_q, pwr_ack_q, sleep_ack_q;
  logic       iso_d, clk_en_d, rst_n_d, pwr_ack_d, sleep_ack_d;

  // A settle value of 0 behaves like 1 so the rail always gets at least one cycle.
  assign settle_last  = (bus.i_settle_cycles == 8'd0) ? 8'd0 : bus.i_settle_cycles - 8'd1;
  assign timeout_last = bus.i_idle_timeout - 8'd1;

  always_ff @(posedge i_aon_clk or negedge i_soc_pwr_on_rst_n) begin
    if (!i_soc_pwr_on_rst_n) begin
      idle_meta <= 1'b0;
      idle_s    <= 1'b0;
    end else begin
      idle_meta <= bus.i_pd1_idle;
      idle_s    <= idle_meta;
    end
  end

  always_ff @(posedge i_aon_clk or negedge i_soc_pwr_on_rst_n) begin
    if (!i_soc_pwr_on_rst_n) begin
      state_q <= RAIL_WAIT;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    case (state_q)
      RAIL_WAIT: begin
        if (bus.i_dcdc_enable) begin
          if (cnt_q == settle_last) state_d = RELEASE;
          else                      cnt_d   = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd0;
        end
      end
      RELEASE: state_d = ON;
      ON: begin
        if (bus.i_sleep_req)         state_d = DRAIN;
        else if (!bus.i_dcdc_enable) state_d = CLAMP;
      end
      DRAIN: begin
        if (!bus.i_sleep_req) begin
          state_d = ON;
        end else if (idle_s) begin
          state_d = CLAMP;
        end else if ((bus.i_idle_timeout != 8'd0) && (cnt_q == timeout_last)) begin
          state_d = CLAMP;
          err_set = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      CLAMP: state_d = SLEEP;
      SLEEP: begin
        if (!bus.i_sleep_req) state_d = RAIL_WAIT;
      end
      default: state_d = RAIL_WAIT;
    endcase
    if (state_d != state_q) cnt_d = 8'd0;
  end

  // Outputs are decoded from the next state and registered so PD1 controls never glitch.
  always_comb begin
    iso_d       = 1'b1;
    clk_en_d    = 1'b0;
    rst_n_d     = 1'b0;
    pwr_ack_d   = 1'b0;
    sleep_ack_d = 1'b0;
    case (state_d)
      RELEASE: begin
        iso_d    = 1'b0;
        clk_en_d = 1'b1;
      end
      ON: begin
        iso_d     = 1'b0;
        clk_en_d  = 1'b1;
        rst_n_d   = 1'b1;
        pwr_ack_d = 1'b1;
      end
      DRAIN: begin
        iso_d    = 1'b0;
        clk_en_d = 1'b1;
        rst_n_d  = 1'b1;
      end
      SLEEP:   sleep_ack_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_aon_clk or negedge i_soc_pwr_on_rst_n) begin
    if (!i_soc_pwr_on_rst_n) begin
      iso_q       <= 1'b1;
      clk_en_q    <= 1'b0;
      rst_n_q     <= 1'b0;
      pwr_ack_q   <= 1'b0;
      sleep_ack_q <= 1'b0;
    end else begin
      iso_q       <= iso_d;
      clk_en_q    <= clk_en_d;
      rst_n_q     <= rst_n_d;
      pwr_ack_q   <= pwr_ack_d;
      sleep_ack_q <= sleep_ack_d;
    end
  end

  // A timeout that coincides with a clear wins, so no forced drain goes unreported.
  always_ff @(posedge i_aon_clk or negedge i_soc_pwr_on_rst_n) begin
    if (!i_soc_pwr_on_rst_n)  timeout_err_q <= 1'b0;
    else if (err_set)         timeout_err_q <= 1'b1;
    else if (bus.i_err_clr)   timeout_err_q <= 1'b0;
  end

  assign bus.o_iso_en       = iso_q;
  assign bus.o_pd1_clk_en   = clk_en_q;
  assign bus.o_pd1_rst_n    = rst_n_q;
  assign bus.o_pwr_on_ack   = pwr_ack_q;
  assign bus.o_hw_sleep_ack = sleep_ack_q;
  assign bus.o_timeout_err  = timeout_err_q;
  assign bus.o_state        = state_q;

endmodule
